// File: rtl/flow_queue_store.sv
// Per-flow FIFO store: FLOWS independent queues of DEPTH (rank, value) entries
// sharing one storage array, with single-cycle registered pop output.
`timescale 1ns/1ps
module flow_queue_store #(
  parameter int FLOWS   = 10,
  parameter int DEPTH   = 50,
  parameter int RANK_W  = 32,
  parameter int VALUE_W = 32,
  localparam int FLOW_W = $clog2(FLOWS),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_valid,
  input  logic [FLOW_W-1:0]       push_flow,
  input  logic [RANK_W-1:0]       push_rank,
  input  logic [VALUE_W-1:0]      push_value,
  output logic                    push_ready,
  input  logic                    pop_req,
  input  logic [FLOW_W-1:0]       pop_flow,
  output logic                    out_valid,
  output logic [RANK_W-1:0]       out_rank,
  output logic [VALUE_W-1:0]      out_value,
  output logic [FLOW_W-1:0]       out_flow,
  output logic [FLOWS-1:0]        empty,
  output logic [FLOWS-1:0]        full,
  output logic [FLOWS*RANK_W-1:0] head_rank,
  input  logic [FLOW_W-1:0]       count_sel,
  output logic [CNT_W-1:0]        count,
  output logic                    err_push,
  output logic                    err_pop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [RANK_W-1:0]  rank_mem  [FLOWS][DEPTH];
  logic [VALUE_W-1:0] value_mem [FLOWS][DEPTH];
  logic [PTR_W-1:0]   head_q    [FLOWS];
  logic [PTR_W-1:0]   tail_q    [FLOWS];
  logic [CNT_W-1:0]   cnt_q     [FLOWS];

  logic [FLOWS-1:0] push_sel;
  logic [FLOWS-1:0] pop_sel;
  logic [PTR_W-1:0] push_tail;
  logic [PTR_W-1:0] pop_head;
  logic             push_ok;
  logic             pop_ok;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // One-hot flow decode; an out-of-range index selects nothing and is rejected.
  always_comb begin
    push_sel  = '0;
    pop_sel   = '0;
    push_tail = '0;
    pop_head  = '0;
    count     = '0;
    empty     = '0;
    full      = '0;
    for (int f = 0; f < FLOWS; f++) begin
      push_sel[f] = (push_flow == FLOW_W'(f));
      pop_sel[f]  = (pop_flow == FLOW_W'(f));
      empty[f]    = (cnt_q[f] == '0);
      full[f]     = (cnt_q[f] == CNT_W'(DEPTH));
      if (push_flow == FLOW_W'(f)) push_tail = tail_q[f];
      if (pop_flow == FLOW_W'(f))  pop_head  = head_q[f];
      if (count_sel == FLOW_W'(f)) count     = cnt_q[f];
    end
  end

  assign push_ready = |(push_sel & ~full);
  assign push_ok    = push_valid && push_ready;
  assign pop_ok     = pop_req && |(pop_sel & ~empty);

  always_comb begin
    head_rank = '0;
    for (int f = 0; f < FLOWS; f++) begin
      if (cnt_q[f] != '0) head_rank[f*RANK_W +: RANK_W] = rank_mem[f][head_q[f]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < FLOWS; f++) begin
        head_q[f] <= '0;
        tail_q[f] <= '0;
        cnt_q[f]  <= '0;
      end
    end else begin
      for (int f = 0; f < FLOWS; f++) begin
        if (push_ok && push_sel[f]) tail_q[f] <= next_ptr(tail_q[f]);
        if (pop_ok && pop_sel[f])   head_q[f] <= next_ptr(head_q[f]);
        case ({push_ok && push_sel[f], pop_ok && pop_sel[f]})
          2'b10:   cnt_q[f] <= cnt_q[f] + CNT_W'(1);
          2'b01:   cnt_q[f] <= cnt_q[f] - CNT_W'(1);
          default: cnt_q[f] <= cnt_q[f];
        endcase
      end
    end
  end

  // Storage is deliberately left unreset; only occupied slots are ever read out.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      rank_mem[push_flow][push_tail]  <= push_rank;
      value_mem[push_flow][push_tail] <= push_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_rank  <= '0;
      out_value <= '0;
      out_flow  <= '0;
      err_push  <= 1'b0;
      err_pop   <= 1'b0;
    end else begin
      out_valid <= pop_ok;
      err_push  <= push_valid && !push_ready;
      err_pop   <= pop_req && !pop_ok;
      if (pop_ok) begin
        out_rank  <= rank_mem[pop_flow][pop_head];
        out_value <= value_mem[pop_flow][pop_head];
        out_flow  <= pop_flow;
      end
    end
  end

endmodule

// File: doc/flow_queue_store.md
FLOW_QUEUE_STORE -- requirements
Module: flow_queue_store

Interface
REQ-001 Parameter FLOWS, default 10: number of independent per-flow FIFOs; legal range 2..64.
REQ-002 Parameter DEPTH, default 50: entries per flow; legal range 2..1024; need not be a power of two.
REQ-003 Parameter RANK_W, default 32: rank field width in bits.
REQ-004 Parameter VALUE_W, default 32: value field width in bits.
REQ-005 Derived FLOW_W = $clog2(FLOWS); derived CNT_W = $clog2(DEPTH+1).
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 push_valid  in  1  enqueue request.
REQ-009 push_flow  in  FLOW_W  binary index of the target flow.
REQ-010 push_rank  in  RANK_W  rank to store.
REQ-011 push_value  in  VALUE_W  value to store.
REQ-012 push_ready  out  1  combinational: push_flow < FLOWS and flow push_flow not full.
REQ-013 pop_req  in  1  dequeue request.
REQ-014 pop_flow  in  FLOW_W  binary index of the flow to pop.
REQ-015 out_valid  out  1  registered; high one cycle per accepted pop.
REQ-016 out_rank / out_value / out_flow  out  RANK_W / VALUE_W / FLOW_W  registered popped entry and its flow.
REQ-017 empty / full  out  FLOWS each  per-flow status, registered state.
REQ-018 head_rank  out  FLOWS*RANK_W  flat; slice f = rank at head of flow f; 0 when flow f is empty.
REQ-019 count_sel  in  FLOW_W; count  out  CNT_W  combinational occupancy of flow count_sel.
REQ-020 err_push  out  1; err_pop  out  1  registered one-cycle error pulses.

Function
REQ-021 Each flow SHALL be a FIFO with its own head pointer, tail pointer and occupancy counter.
REQ-022 Push SHALL be accepted iff push_valid && push_ready; the entry is written at tail, tail advances, and count increments on that edge.
REQ-023 Pop SHALL be accepted iff pop_req && pop_flow < FLOWS && !empty[pop_flow]; head advances and count decrements on that edge.
REQ-024 Pop latency SHALL be 1 cycle: out_valid/out_rank/out_value/out_flow present the head entry the cycle after acceptance.
REQ-025 out_rank/out_value/out_flow SHALL hold their last values when out_valid is low.
REQ-026 Head and tail pointers SHALL wrap from DEPTH-1 to 0 (modulo DEPTH, not power-of-two masking).
REQ-027 empty[f] SHALL equal (count_f == 0); full[f] SHALL equal (count_f == DEPTH).
REQ-028 Simultaneous push and pop to different flows SHALL both be accepted when individually legal.
REQ-029 Simultaneous push and pop to the same non-empty, non-full flow SHALL both be accepted; count is unchanged.
REQ-030 Same-flow push and pop while the flow is empty: push accepted, pop rejected (no bypass), err_pop pulses.
REQ-031 Same-flow push and pop while the flow is full: pop accepted, push rejected (push_ready low), err_push pulses.
REQ-032 err_push SHALL pulse the cycle after push_valid && !push_ready; err_pop SHALL pulse the cycle after a rejected pop_req; rejected requests change no state.
REQ-033 Flow index >= FLOWS SHALL be treated as rejected for both push and pop.
REQ-034 head_rank and count SHALL be combinational from current state and SHALL reflect an edge's updates only after that edge.

Reset
REQ-035 On rst, all heads, tails and counts SHALL be cleared to 0; empty = all ones; full = all zeros.
REQ-036 On rst, out_valid, err_push and err_pop SHALL be 0; out_rank, out_value and out_flow SHALL be 0.
REQ-037 rst SHALL take priority over simultaneous push/pop in that cycle; neither is accepted.
REQ-038 Storage arrays SHALL NOT be reset; no output depends on unwritten storage.

Verification
REQ-039 Reset, then push (flow 3, rank 7, value 0xA5), then pop flow 3 -> out_valid=1 one cycle after the pop, with out_rank=7, out_value=0xA5, out_flow=3; empty[3]=1 afterward.
REQ-040 DEPTH=4: push 4 entries to flow 0, then a 5th push -> push_ready=0, err_push pulse, full[0]=1, count=4; popping all 4 returns them in FIFO order.
REQ-041 Wrap: push 3 and pop 3 repeatedly on flow 1 for 10 rounds with DEPTH=4 -> data is in order every round and count returns to 0.
REQ-042 Flow 2 empty, same-cycle push(rank 9) and pop on flow 2 -> no out_valid, err_pop pulses, count=1, head_rank slice 2 = 9.
REQ-043 Flow 5 full, same-cycle push and pop -> pop returns the oldest entry, push rejected, count stays DEPTH-1; pop_flow=FLOWS -> err_pop pulses.
REQ-044 Assert rst while flows 0 and 1 hold data and a pop is issued -> out_valid=0 the next cycle and all flows empty.
